sha256_msg_padder: RTL



---
 rtl/sha256_pkg.sv | 24 ++
 rtl/sha256_msg_padder_if.sv | 26 ++
 rtl/sha256_pad_word_sel.sv | 41 ++++
 rtl/sha256_msg_padder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions used by the message padder and the hash core.
// Build option: SHA_PAD_BSWAP_EN (consumed by sha256_pad_word_sel).
package sha256_pkg;

  localparam int unsigned BLOCK_WORDS = 16;
  localparam logic [31:0] PAD_MARKER  = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StPresent
  } pad_state_e;

  // Blocks needed for a message of 'words' 32-bit words plus marker and 64-bit length.
  function automatic int unsigned num_blocks(input int unsigned words);
    return ((words + 2) / BLOCK_WORDS) + 1;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Padded-block stream from the message padder to the hash core.
interface sha256_msg_padder_if;

  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
  logic [7:0]   blk_index;

  modport master (
    output blk_valid,
    output blk_data,
    output blk_last,
    output blk_index,
    input  blk_ready
  );

  modport slave (
    input  blk_valid,
    input  blk_data,
    input  blk_last,
    input  blk_index,
    output blk_ready
  );

endinterface

// File: rtl/sha256_pad_word_sel.sv
// Per-slot word selection for the padder: decides whether slot w of the current
// block comes from memory or is a padding/length word.
// Build option: SHA_PAD_BSWAP_EN byte-reverses words read from memory.
module sha256_pad_word_sel
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_OF_WORDS = 20
) (
  input  logic [15:0] g,
  input  logic [3:0]  w,
  input  logic        is_last,
  input  logic [31:0] mem_word,
  output logic        rd_issue,
  output logic [31:0] fill_word,
  output logic [31:0] cap_word
);

  localparam logic [15:0] NumWords = 16'(NUM_OF_WORDS);
  localparam logic [31:0] BitLen   = 32'(NUM_OF_WORDS * 32);

  // Message slots are read; everything past the message is synthesised here.
  always_comb begin
    rd_issue  = (g < NumWords);
    fill_word = '0;
    if (g == NumWords) begin
      fill_word = PAD_MARKER;
    end else if (is_last && (w == 4'd15)) begin
      fill_word = BitLen;
    end
  end

  // Memory word as it should land in the block buffer.
  always_comb begin
`ifdef SHA_PAD_BSWAP_EN
    cap_word = bswap32(mem_word);
`else
    cap_word = mem_word;
`endif
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Reads a NUM_OF_WORDS-word message from synchronous memory, appends SHA-256
// padding and presents each 512-bit block over a valid/ready handshake.
// Build option: SHA_PAD_BSWAP_EN (little-endian message memory).
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_OF_WORDS = 20
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [15:0]                message_addr,
  output logic                       mem_clk,
  output logic [15:0]                mem_addr,
  input  logic [31:0]                mem_read_data,
  sha256_msg_padder_if.master        blk_if,
  output logic                       done
);

  localparam int unsigned NUM_BLOCKS = num_blocks(NUM_OF_WORDS);
  localparam logic [7:0]  LastBlk    = 8'(NUM_BLOCKS - 1);

  pad_state_e  state_q, state_d;
  logic [15:0] base_q;
  logic [7:0]  blk_q, blk_d;
  logic [3:0]  w_q, w_d;
  logic [15:0] mem_addr_q;
  logic        pend_q;
  logic [3:0]  pend_slot_q;
  logic [31:0] word_q [BLOCK_WORDS];

  logic [15:0] g;
  logic        is_last;
  logic        in_fetch;
  logic        rd_issue;
  logic        issue;
  logic [31:0] fill_word;
  logic [31:0] cap_word;

  assign mem_clk  = clk;
  assign g        = {4'h0, blk_q, w_q};
  assign is_last  = (blk_q == LastBlk);
  assign in_fetch = (state_q == StFetch);
  assign issue    = in_fetch && rd_issue;

  sha256_pad_word_sel #(
    .NUM_OF_WORDS(NUM_OF_WORDS)
  ) u_word_sel (
    .g        (g),
    .w        (w_q),
    .is_last  (is_last),
    .mem_word (mem_read_data),
    .rd_issue (rd_issue),
    .fill_word(fill_word),
    .cap_word (cap_word)
  );

  // Address is driven in the issuing cycle so data returns in the next one.
  assign mem_addr = issue ? (base_q + g) : mem_addr_q;

  // Next-state: 16 fetch cycles, one drain cycle, then hold until accepted.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    w_d     = w_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          blk_d   = '0;
          w_d     = '0;
        end
      end
      StFetch: begin
        w_d = w_q + 4'd1;
        if (w_q == 4'd15) state_d = StDrain;
      end
      StDrain: state_d = StPresent;
      StPresent: begin
        if (blk_if.blk_ready) begin
          if (is_last) begin
            state_d = StIdle;
          end else begin
            state_d = StFetch;
            blk_d   = blk_q + 8'd1;
            w_d     = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, latched base address and read-pipeline tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      blk_q       <= '0;
      w_q         <= '0;
      mem_addr_q  <= '0;
      pend_q      <= 1'b0;
      pend_slot_q <= '0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      w_q         <= w_d;
      mem_addr_q  <= mem_addr;
      pend_q      <= issue;
      pend_slot_q <= w_q;
      if ((state_q == StIdle) && start) base_q <= message_addr;
    end
  end

  // Block buffer: the returning read and a padding fill may land in the same
  // cycle, always in different slots (w-1 and w).
  always_ff @(posedge clk) begin
    if (pend_q) word_q[pend_slot_q] <= cap_word;
    if (in_fetch && !rd_issue) word_q[w_q] <= fill_word;
  end

  // Block stream outputs; word 0 occupies the most significant bits.
  always_comb begin
    blk_if.blk_valid = (state_q == StPresent);
    blk_if.blk_last  = (state_q == StPresent) && is_last;
    blk_if.blk_index = blk_q;
    blk_if.blk_data  = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      blk_if.blk_data[511 - 32*i -: 32] = word_q[i];
    end
  end

  assign done = (state_q == StIdle);

endmodule
